// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch sequencer: PC, single-outstanding ROM requests, tagged buffer toward decode
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        rom_req,
  output logic [31:0] rom_addr,
  input  logic        rom_ack,
  input  logic [31:0] rom_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          rom_req_q, rom_req_d;
  logic [31:0]   rom_addr_q, rom_addr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [63:0]   mem_q [DEPTH];
  logic [63:0]   mem_d [DEPTH];

  logic          push, pop, issue;
  logic [AW:0]   count_after;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    rom_req_d   = rom_req_q;
    rom_addr_d  = rom_addr_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_d       = mem_q;
    push        = 1'b0;
    pop         = 1'b0;
    issue       = 1'b0;
    count_after = count_q;

    if (redirect) begin
      // Redirect wins over everything: flush, retarget, and drop any returning word.
      pc_d     = redirect_pc;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      if (state_q != S_IDLE) begin
        if (rom_ack) begin
          state_d   = S_IDLE;
          rom_req_d = 1'b0;
        end else begin
          state_d = S_DISCARD;
        end
      end
    end else begin
      pop         = instr_valid && instr_ready;
      push        = (state_q == S_WAIT) && rom_ack;
      count_after = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

      case (state_q)
        S_IDLE:            issue = enable && (count_q < DEPTH_C);
        S_WAIT, S_DISCARD: issue = rom_ack && enable && (count_after < DEPTH_C);
        default:           issue = 1'b0;
      endcase

      if (push) begin
        mem_d[wr_ptr_q] = {rom_addr_q, rom_data};
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_after;

      if (issue) begin
        rom_req_d  = 1'b1;
        rom_addr_d = pc_q;
        pc_d       = pc_q + 32'd1;
        state_d    = S_WAIT;
      end else if ((state_q != S_IDLE) && rom_ack) begin
        rom_req_d = 1'b0;
        state_d   = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      rom_req_q  <= 1'b0;
      rom_addr_q <= RESET_PC;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rom_req_q  <= rom_req_d;
      rom_addr_q <= rom_addr_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Buffer contents need no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rom_req     = rom_req_q;
  assign rom_addr    = rom_addr_q;
  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? mem_q[rd_ptr_q][31:0]  : 32'd0;
  assign instr_pc    = instr_valid ? mem_q[rd_ptr_q][63:32] : 32'd0;
  assign busy        = (state_q != S_IDLE);

endmodule
